// File: rtl/hc595_seg_scan.sv
// Multiplexed 7-segment scan driver for a display behind cascaded 74HC595s.
// Optional leading-zero suppression is enabled by defining HC595_LZ_BLANK_EN.
module hc595_seg_scan #(
  parameter int DIGITS         = 8,
  parameter int CLK_DIV        = 2,
  parameter int HOLD_CYCLES    = 16,
  parameter bit SEG_ACTIVE_LOW = 1
) (
  input  logic                  clk1,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   dis_data,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic [DIGITS-1:0]     blank_mask,
  output logic                  ds_stcp,
  output logic                  ds_shcp,
  output logic                  ds_data,
  output logic                  frame_done
);

  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DIGITS - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, HOLD} state_t;

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic [3:0]          bit_cnt;
  logic [DIV_W-1:0]    div_cnt;
  logic                phase;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [15:0]         shreg;
  logic [15:0]         frame;
  logic [3:0]          nib;
  logic [7:0]          seg;
  logic [7:0]          sel;
  logic [7:0]          sel_rev;

  function automatic logic [7:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_seg = 8'hC0;
      4'h1: hex_seg = 8'hF9;
      4'h2: hex_seg = 8'hA4;
      4'h3: hex_seg = 8'hB0;
      4'h4: hex_seg = 8'h99;
      4'h5: hex_seg = 8'h92;
      4'h6: hex_seg = 8'h82;
      4'h7: hex_seg = 8'hF8;
      4'h8: hex_seg = 8'h80;
      4'h9: hex_seg = 8'h90;
      4'hA: hex_seg = 8'h88;
      4'hB: hex_seg = 8'h83;
      4'hC: hex_seg = 8'hC6;
      4'hD: hex_seg = 8'hA1;
      4'hE: hex_seg = 8'h86;
      default: hex_seg = 8'h8E;
    endcase
  endfunction

`ifdef HC595_LZ_BLANK_EN
  logic upper_nz;
`endif

  // Frame for the current digit: segment byte MSB first, then select LSB first.
  always_comb begin
    nib = dis_data[{idx, 2'b00} +: 4];
    seg = hex_seg(nib);
    if (dp_mask[idx]) seg[7] = 1'b0;
`ifdef HC595_LZ_BLANK_EN
    upper_nz = 1'b0;
    for (int j = 0; j < DIGITS; j++) begin
      if (j >= int'(idx) && dis_data[4*j +: 4] != 4'h0) upper_nz = 1'b1;
    end
    if (idx != '0 && !upper_nz && !dp_mask[idx]) seg = 8'hFF;
`endif
    if (blank_mask[idx]) seg = 8'hFF;
    sel = ~(8'd1 << idx);
    if (!SEG_ACTIVE_LOW) begin
      seg = ~seg;
      sel = ~sel;
    end
    for (int i = 0; i < 8; i++) sel_rev[i] = sel[7-i];
    frame = {seg, sel_rev};
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      bit_cnt    <= '0;
      div_cnt    <= '0;
      phase      <= 1'b0;
      hold_cnt   <= '0;
      ds_stcp    <= 1'b0;
      ds_shcp    <= 1'b0;
      ds_data    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      ds_stcp    <= 1'b0;
      ds_shcp    <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          ds_data <= 1'b0;
          if (en) state <= LOAD;
        end
        LOAD: begin
          bit_cnt <= '0;
          div_cnt <= '0;
          phase   <= 1'b0;
          state   <= SHIFT;
        end
        SHIFT: begin
          ds_shcp <= phase;
          if (!phase) ds_data <= shreg[15];
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            phase   <= ~phase;
            if (phase) begin
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd15) state <= LATCH;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        LATCH: begin
          ds_stcp <= 1'b1;
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            hold_cnt <= '0;
            state    <= HOLD;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            idx        <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            frame_done <= (idx == LAST_IDX);
            state      <= en ? LOAD : IDLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shift register is pure data: loaded in LOAD, advanced after each shcp high phase.
  always_ff @(posedge clk1) begin
    if (state == LOAD) begin
      shreg <= frame;
    end else if (state == SHIFT && phase && div_cnt == DIV_LAST) begin
      shreg <= {shreg[14:0], 1'b0};
    end
  end

endmodule

// File: doc/hc595_seg_scan.md
Name: hc595_seg_scan

Overview:
- Parametrised multiplexed 7-segment scan driver for a display behind cascaded 74HC595 shift registers.
- Per scan slot it shifts a 16-bit frame over ds_data/ds_shcp: 8 segment bits, then 8 digit-select bits. It then pulses ds_stcp and holds the digit lit.
- Successor to the fixed 4-digit driver: configurable digit count, shift rate, hold time and polarity, plus per-digit decimal-point/blank masks, an explicit FSM and a frame-done strobe.

Parameters:
- DIGITS, 8: number of scanned digits, 1..8.
- CLK_DIV, 2: clk1 cycles per shcp half-period, >=1.
- HOLD_CYCLES, 16: clk1 cycles a latched digit is held before the next load, >=1.
- SEG_ACTIVE_LOW, 1: 1 = segment and select bytes active-low; 0 = both bytes inverted.

Ports:
- clk1  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  scan enable
- dis_data  in  4*DIGITS  hex nibbles; digit k = dis_data[4k+3:4k]
- dp_mask  in  DIGITS  1 = light decimal point of digit k
- blank_mask  in  DIGITS  1 = digit k fully dark
- ds_stcp  out  1  595 storage (latch) clock
- ds_shcp  out  1  595 shift clock
- ds_data  out  1  595 serial data
- frame_done  out  1  one-cycle pulse after last digit's latch

Behaviour:
- Reset (asynchronous, rst_n low):
  - ds_stcp, ds_shcp, ds_data, frame_done = 0.
  - State IDLE, digit index = 0, bit counter = 0.
- FSM states: IDLE, LOAD, SHIFT, LATCH, HOLD.
- IDLE: all outputs 0. If en=1, go to LOAD next cycle.
- LOAD (1 cycle): snapshot digit[idx] into a 16-bit shift register, bit counter = 0. Inputs are sampled only here; changes during the transfer do not affect it.
  - Segment byte (active-low) uses hex table 0..F = C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E.
  - dp_mask[idx]=1 clears bit7.
  - blank_mask[idx]=1 forces FF, overriding dp.
  - Select byte = ~(1<<idx).
  - SEG_ACTIVE_LOW=0 inverts both bytes.
- SHIFT (16 bits): order seg[7]..seg[0], then sel[0]..sel[7].
  - Each bit is 2*CLK_DIV cycles: CLK_DIV cycles with shcp=0 and ds_data = bit, then CLK_DIV cycles with shcp=1, data stable.
  - ds_data changes only while shcp=0.
- LATCH: shcp=0, ds_stcp=1 for CLK_DIV cycles; ds_data holds the last bit.
- HOLD: ds_stcp=0 for HOLD_CYCLES cycles.
  - Then idx = (idx==DIGITS-1) ? 0 : idx+1.
  - frame_done=1 for the single cycle the wrap occurs.
  - Next state is LOAD if en=1, else IDLE.
- Slot period = 1 + 33*CLK_DIV + HOLD_CYCLES clk1 cycles (defaults: 83).
- en low mid-slot: the current slot always completes through HOLD, then IDLE. idx is retained; scan resumes at the next digit.
- Reset mid-operation: immediate return to the reset values above. No partial latch pulse.
- No unused select bits are driven active: bits >= DIGITS are always inactive.

Optional Feature:
- Macro: HC595_LZ_BLANK_EN.
- Defined: leading-zero suppression.
  - In LOAD, digit k (k>0) is forced blank (FF) if its nibble and all higher nibbles are 0 and dp_mask[k]=0.
  - Digit 0 is never suppressed.
- Undefined: zeros are displayed as C0; no extra logic.

Test Plan:
- Reset: rst_n low mid-SHIFT -> ds_stcp/ds_shcp/ds_data/frame_done = 0 immediately. After release with en=1, the first slot is digit 0.
- DIGITS=4, defaults, dis_data=16'h1234, en=1 -> first frame bits 1,0,0,1,1,0,0,1 (0x99), then 0,1,1,1,1,1,1,1 (0xFE). stcp high 2 cycles at cycle 66..67 after LOAD. Next LOAD at cycle 83.
- Same config -> select bytes FE,FD,FB,F7 in sequence. frame_done pulses once every 332 cycles. idx wraps 3->0.
- dp_mask=4'b0001, blank_mask=4'b0010 -> digit0 segment byte 0x19. digit1 segment byte 0xFF.
- en dropped during SHIFT of digit2 -> digit2 completes (stcp pulse, HOLD), then IDLE with outputs 0. en re-asserted -> next slot is digit3.
- HC595_LZ_BLANK_EN defined, dis_data=16'h0050 -> digit3, digit2 = FF; digit1 = 0x92; digit0 = C0. Undefined -> digit3 and digit2 = C0.
